pipe_wb_reg: RTL and testbench
==============================

# pipe_wb_reg

Parametrised memory-to-writeback pipeline register for the Y86-64 pipelined processor, sitting between the memory stage and register-file writeback. It extends the plain M→W latch with stall and bubble control, a valid flag, a halt latch that freezes the writeback stage on the first exceptional status, and a retired-instruction counter. Datapath and register-ID widths are generic, so the same block serves the 64-bit core and narrower test configurations.

## Interface
Parameters:
- VAL_W, 64, width of valE/valM datapath
- REG_W, 4, width of register IDs
- CNT_W, 32, width of retire counter
- STAT_BUB, 3'd0, status code for a bubble
- STAT_AOK, 3'd1, normal status
- ICODE_NOP, 4'h1, icode loaded on bubble/reset
- REG_NONE, all-ones of REG_W, "no register" ID

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- m_stat  in  3  status from memory stage
- m_icode  in  4  icode from memory stage
- M_valE  in  VAL_W  ALU result
- m_valM  in  VAL_W  memory read data
- M_dstE  in  REG_W  destination for valE
- M_dstM  in  REG_W  destination for valM
- W_stall  in  1  hold current contents
- W_bubble  in  1  load a bubble
- W_stat  out  3  registered status
- W_icode  out  4  registered icode
- W_valE, W_valM  out  VAL_W  registered values
- W_dstE, W_dstM  out  REG_W  registered destinations
- W_valid  out  1  1 = holds a real (non-bubble) instruction
- halted  out  1  sticky: writeback frozen on exception
- retire_cnt  out  CNT_W  instructions retired since reset

## Operation
- States: RUN, HALTED (halted=1). HALTED is left only via rst_n.
- Per-edge priority in RUN: stall > bubble > load.
  - W_stall=1: all outputs hold; counter holds. W_stall with W_bubble: stall wins.
  - W_bubble=1 (no stall): W_stat=STAT_BUB, W_icode=ICODE_NOP, W_dstE=W_dstM=REG_NONE, W_valE=W_valM=0, W_valid=0.
  - Otherwise load: all W_* take M-stage inputs; W_valid = (m_stat != STAT_BUB).
- Retire: on a load with m_stat==STAT_AOK, retire_cnt += 1, wrapping modulo 2^CNT_W (all-ones → 0).
- Halt: on a load with m_stat not in {STAT_BUB, STAT_AOK} (HLT/ADR/INS), the instruction is loaded, the counter does not increment, and halted is set at the same edge. In HALTED, every output holds regardless of W_stall, W_bubble, or inputs.
- Exceptional instruction's dstE/dstM are still presented; suppressing register writes on W_stat != AOK is the register file's job.

## Timing
- All outputs are registered; latency M inputs → W outputs = 1 cycle.
- Reset (rst_n=0, asynchronous, any time including mid-stall or HALTED): W_stat=STAT_BUB, W_icode=ICODE_NOP, W_dstE=W_dstM=REG_NONE, W_valE=W_valM=0, W_valid=0, halted=0, retire_cnt=0, state RUN. First load occurs on the first rising edge after rst_n deasserts.
- halted and the exceptional W_stat become visible in the same cycle.
- W_stall/W_bubble are sampled only at the rising edge; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive garbage inputs, rst_n=0 mid-cycle → outputs immediately W_stat=0, W_icode=1, dst=4'hF, vals=0, valid=0, halted=0, retire_cnt=0.
- Load: m_stat=1, m_icode=6, M_valE=64'h15, M_dstE=3 for 3 consecutive edges → W_* match after 1 cycle; W_valid=1; retire_cnt=3.
- Stall and bubble: load an OPq, then W_stall=1 with new inputs for 2 cycles → outputs and counter hold; then W_stall=W_bubble=1 → still hold; then W_bubble=1 alone → bubble values, W_valid=0, counter unchanged.
- Halt: load m_stat=2 (HLT), m_icode=0 → halted=1, W_stat=2, counter unchanged; then 5 cycles of AOK loads and bubbles → no output change; rst_n pulse → clean reset values.
- Counter wrap: CNT_W=4, 17 AOK loads → retire_cnt=1.
- Bubble status passthrough: load m_stat=0 → W_valid=0, no retire, no halt.

Source files
------------

// File: rtl/pipe_wb_reg.sv
// Memory-to-writeback pipeline register with stall/bubble control,
// sticky halt on the first exceptional status, and a retired-instruction counter.
module pipe_wb_reg #(
    parameter int unsigned      VAL_W     = 64,
    parameter int unsigned      REG_W     = 4,
    parameter int unsigned      CNT_W     = 32,
    parameter logic [2:0]       STAT_BUB  = 3'd0,
    parameter logic [2:0]       STAT_AOK  = 3'd1,
    parameter logic [3:0]       ICODE_NOP = 4'h1,
    parameter logic [REG_W-1:0] REG_NONE  = {REG_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [VAL_W-1:0] M_valE,
    input  logic [VAL_W-1:0] m_valM,
    input  logic [REG_W-1:0] M_dstE,
    input  logic [REG_W-1:0] M_dstM,
    input  logic             W_stall,
    input  logic             W_bubble,
    output logic [2:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [VAL_W-1:0] W_valE,
    output logic [VAL_W-1:0] W_valM,
    output logic [REG_W-1:0] W_dstE,
    output logic [REG_W-1:0] W_dstM,
    output logic             W_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned STAT_W  = 3;
    localparam int unsigned ICODE_W = 4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [VAL_W-1:0]   val_e;
        logic [VAL_W-1:0]   val_m;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
        logic               valid;
    } wb_t;

    localparam wb_t WB_BUBBLE = '{
        stat:  STAT_BUB,
        icode: ICODE_NOP,
        val_e: '0,
        val_m: '0,
        dst_e: REG_NONE,
        dst_m: REG_NONE,
        valid: 1'b0
    };

    state_t           state, state_next;
    wb_t              wb_q, wb_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;

    // State, payload and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wb_q  <= WB_BUBBLE;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            wb_q  <= wb_next;
            cnt_q <= cnt_next;
        end
    end

    // Next-state: HALTED freezes everything; in RUN stall > bubble > load
    always_comb begin
        state_next = state;
        wb_next    = wb_q;
        cnt_next   = cnt_q;
        if (state == RUN && !W_stall) begin
            if (W_bubble) begin
                wb_next = WB_BUBBLE;
            end else begin
                wb_next.stat  = m_stat;
                wb_next.icode = m_icode;
                wb_next.val_e = M_valE;
                wb_next.val_m = m_valM;
                wb_next.dst_e = M_dstE;
                wb_next.dst_m = M_dstM;
                wb_next.valid = (m_stat != STAT_BUB);
                if (m_stat == STAT_AOK) begin
                    cnt_next = cnt_q + CNT_W'(1);
                end else if (m_stat != STAT_BUB) begin
                    state_next = HALTED;
                end
            end
        end
    end

    assign W_stat     = wb_q.stat;
    assign W_icode    = wb_q.icode;
    assign W_valE     = wb_q.val_e;
    assign W_valM     = wb_q.val_m;
    assign W_dstE     = wb_q.dst_e;
    assign W_dstM     = wb_q.dst_m;
    assign W_valid    = wb_q.valid;
    assign halted     = (state == HALTED);
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Scoreboard bench for pipe_wb_reg: a driver pushes expected writeback state,
// a monitor pops and compares one entry after every rising edge.
module tb_pipe_wb_reg;

    localparam int unsigned VAL_W = 64;
    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       m_stat = 3'd0;
    logic [3:0]       m_icode = 4'd0;
    logic [VAL_W-1:0] M_valE = '0;
    logic [VAL_W-1:0] m_valM = '0;
    logic [REG_W-1:0] M_dstE = '0;
    logic [REG_W-1:0] M_dstM = '0;
    logic             W_stall = 1'b1;
    logic             W_bubble = 1'b0;
    logic [2:0]       W_stat;
    logic [3:0]       W_icode;
    logic [VAL_W-1:0] W_valE, W_valM;
    logic [REG_W-1:0] W_dstE, W_dstM;
    logic             W_valid, halted;
    logic [CNT_W-1:0] retire_cnt;

    pipe_wb_reg #(.VAL_W(VAL_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_stat(m_stat), .m_icode(m_icode), .M_valE(M_valE), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valid(W_valid), .halted(halted),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       stat;
        logic [3:0]       icode;
        logic [VAL_W-1:0] val_e;
        logic [VAL_W-1:0] val_m;
        logic [REG_W-1:0] dst_e;
        logic [REG_W-1:0] dst_m;
        logic             valid;
        logic             halted;
        int               cnt;
    } exp_t;

    exp_t mdl;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t reset_value();
        exp_t r;
        r.stat = 3'd0; r.icode = 4'h1; r.val_e = '0; r.val_m = '0;
        r.dst_e = 4'hF; r.dst_m = 4'hF; r.valid = 1'b0; r.halted = 1'b0; r.cnt = 0;
        return r;
    endfunction

    task automatic compare(input string nm, input exp_t e);
        checks++;
        if (W_stat !== e.stat || W_icode !== e.icode || W_valE !== e.val_e ||
            W_valM !== e.val_m || W_dstE !== e.dst_e || W_dstM !== e.dst_m ||
            W_valid !== e.valid || halted !== e.halted ||
            retire_cnt !== CNT_W'(e.cnt)) begin
            errors++;
            $display("FAIL %s @%0t: got stat=%0d icode=%0d valE=%h valM=%h dstE=%0d dstM=%0d valid=%0b halted=%0b cnt=%0d; expected stat=%0d icode=%0d valE=%h valM=%h dstE=%0d dstM=%0d valid=%0b halted=%0b cnt=%0d",
                     nm, $time, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, W_valid, halted, retire_cnt,
                     e.stat, e.icode, e.val_e, e.val_m, e.dst_e, e.dst_m, e.valid, e.halted, e.cnt);
        end
    endtask

    // Monitor: one expected entry per rising edge while the driver is active
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare("wb_out", e);
            end
        end
    end

    // Behavioural reference: apply the writeback-stage rules for one edge
    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [VAL_W-1:0] ve, input logic [VAL_W-1:0] vm,
                         input logic [REG_W-1:0] de, input logic [REG_W-1:0] dm,
                         input logic stall, input logic bubble);
        @(negedge clk);
        m_stat = st; m_icode = ic; M_valE = ve; m_valM = vm;
        M_dstE = de; M_dstM = dm; W_stall = stall; W_bubble = bubble;
        if (!mdl.halted && !stall) begin
            if (bubble) begin
                mdl.stat = 3'd0; mdl.icode = 4'h1; mdl.val_e = '0; mdl.val_m = '0;
                mdl.dst_e = 4'hF; mdl.dst_m = 4'hF; mdl.valid = 1'b0;
            end else begin
                mdl.stat = st; mdl.icode = ic; mdl.val_e = ve; mdl.val_m = vm;
                mdl.dst_e = de; mdl.dst_m = dm; mdl.valid = (st != 3'd0);
                if (st == 3'd1)
                    mdl.cnt = (mdl.cnt + 1) % (1 << CNT_W);
                else if (st != 3'd0)
                    mdl.halted = 1'b1;
            end
        end
        sb.push_back(mdl);
    endtask

    // Asynchronous reset mid-cycle with garbage on the inputs
    task automatic reset_pulse();
        @(negedge clk);
        m_stat = 3'($urandom); m_icode = 4'($urandom);
        M_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
        M_dstE = 4'($urandom); M_dstM = 4'($urandom);
        W_stall = 1'($urandom); W_bubble = 1'($urandom);
        #2 rst_n = 1'b0;
        #1;
        mdl = reset_value();
        compare("async_reset", mdl);
        W_stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_drive();
        logic [2:0] st;
        int r;
        r = int'($urandom_range(0, 99));
        st = (r < 70) ? 3'd1 : (r < 90) ? 3'd0 : 3'($urandom_range(2, 7));
        drive(st, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom), 4'($urandom),
              $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2);
    endtask

    initial begin
        mdl = reset_value();
        reset_pulse();

        // Three back-to-back AOK loads
        repeat (3) drive(3'd1, 4'h6, 64'h15, 64'h0, 4'h3, 4'hF, 1'b0, 1'b0);

        // Stall, stall+bubble, then bubble alone
        drive(3'd1, 4'h6, 64'hDEAD_BEEF, 64'h0, 4'h2, 4'hF, 1'b0, 1'b0);
        drive(3'd1, 4'h5, 64'h1111, 64'h2222, 4'h7, 4'h8, 1'b1, 1'b0);
        drive(3'd1, 4'h3, 64'h3333, 64'h4444, 4'h9, 4'hA, 1'b1, 1'b0);
        drive(3'd1, 4'h3, 64'h5555, 64'h6666, 4'h1, 4'h2, 1'b1, 1'b1);
        drive(3'd1, 4'h3, 64'h7777, 64'h8888, 4'h4, 4'h5, 1'b0, 1'b1);

        // Bubble status passing through as a load
        drive(3'd0, 4'h1, 64'h99, 64'hAA, 4'h6, 4'h7, 1'b0, 1'b0);

        // Halt, then everything holds until reset
        drive(3'd2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        repeat (5) drive(3'd1, 4'h6, {$urandom, $urandom}, {$urandom, $urandom},
                         4'($urandom), 4'($urandom), 1'b0, 1'($urandom));
        reset_pulse();

        // Counter wrap: 17 AOK loads on a 4-bit counter
        repeat (17) drive(3'd1, 4'h6, {$urandom, $urandom}, 64'h0, 4'h3, 4'hF, 1'b0, 1'b0);

        // Random traffic with occasional recovery from halt
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            if (mdl.halted && $urandom_range(0, 7) == 0)
                reset_pulse();
            else
                rand_drive();
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
